// File: rtl/eth_proto_pkg.sv
// Shared definitions for the protocol receive/reply path: Ethernet header
// constants, the receiver state encoding and a saturating counter helper.
package eth_proto_pkg;

  localparam int          lp_ETH_HDR_BYTES   = 14;
  localparam logic [15:0] lp_ETHERTYPE_ARP   = 16'h0806;
  localparam logic [47:0] lp_BCAST_MAC       = 48'hFFFF_FFFF_FFFF;

  // Ethernet header plus ARP payload; the sender builds replies of this length.
  localparam int          lp_ARP_FRAME_BYTES = lp_ETH_HDR_BYTES + 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SKIP,
    ST_HOLD
  } rx_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_frame_filter.sv
// Combinational accept filter for a captured frame: destination MAC (own or
// broadcast), EtherType and, when enabled, the 4-byte target IP. Byte 0 of
// the frame sits in the MSBs of the capture vector.
module eth_rx_frame_filter
  import eth_proto_pkg::*;
#(
  parameter int          FRAME_BYTES  = lp_ARP_FRAME_BYTES,
  parameter logic [15:0] ETHERTYPE    = lp_ETHERTYPE_ARP,
  parameter bit          IP_MATCH_EN  = 1'b1,
  parameter int          IP_MATCH_OFS = 38
) (
  input  logic [FRAME_BYTES*8-1:0] frame,
  input  logic [47:0]              hw_addr,
  input  logic [31:0]              ip_addr,
  output logic                     match
);

  localparam int lp_W        = FRAME_BYTES * 8;
  localparam int lp_TYPE_OFS = lp_ETH_HDR_BYTES - 2;

  logic [47:0] dst_mac;
  logic [15:0] eth_type;
  logic [31:0] tgt_ip;
  logic        mac_ok;
  logic        type_ok;
  logic        ip_ok;

  assign dst_mac  = frame[lp_W-1 -: 48];
  assign eth_type = frame[lp_W-1-lp_TYPE_OFS*8 -: 16];
  assign tgt_ip   = frame[lp_W-1-IP_MATCH_OFS*8 -: 32];

  assign mac_ok  = (dst_mac == hw_addr) || (dst_mac == lp_BCAST_MAC);
  assign type_ok = (eth_type == ETHERTYPE);
  assign ip_ok   = !IP_MATCH_EN || (tgt_ip == ip_addr);
  assign match   = mac_ok && type_ok && ip_ok;

  // Only header fields are inspected; the remaining payload bits are
  // intentionally ignored here.
  logic unused_frame_bits;
  assign unused_frame_bits = ^frame;

endmodule

// File: rtl/eth_proto_receiver.sv
// Receive side of the protocol path: captures the first FRAME_BYTES bytes of
// each MAC RX frame in place, filters it, and hands accepted frames to the
// consumer through a valid/ack handshake. Frames that cannot be accepted,
// including any that arrive while a frame is held, are counted as drops.
module eth_proto_receiver
  import eth_proto_pkg::*;
#(
  parameter int          FRAME_BYTES  = lp_ARP_FRAME_BYTES,
  parameter logic [15:0] ETHERTYPE    = lp_ETHERTYPE_ARP,
  parameter bit          IP_MATCH_EN  = 1'b1,
  parameter int          IP_MATCH_OFS = 38
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [47:0]              hw_addr_i,
  input  logic [31:0]              ip_addr_i,
  input  logic [7:0]               mac_data_i,
  input  logic                     mac_valid_i,
  input  logic                     mac_last_i,
  input  logic                     mac_err_i,
  output logic [FRAME_BYTES*8-1:0] proto_pkt_o,
  output logic                     proto_pkt_valid_o,
  input  logic                     proto_pkt_ack_i,
  output logic [15:0]              rx_ok_cnt_o,
  output logic [15:0]              rx_drop_cnt_o
);

  localparam int         lp_W        = FRAME_BYTES * 8;
  localparam logic [7:0] lp_LAST_IDX = 8'(FRAME_BYTES - 1);

  rx_state_e   state;
  logic [7:0]  byte_cnt;
  logic [lp_W-1:0] cap_q;
  logic [lp_W-1:0] cap_next;
  logic        byte_wr;
  logic [7:0]  wr_idx;
  logic        frame_match;
  logic        match_q;
  logic        busy_drop;

  // Merge the incoming byte into its slot so the filter sees the frame exactly
  // as it will stand after this edge, including a final byte on this cycle.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    byte_wr  = mac_valid_i && ((state == ST_IDLE) || (state == ST_CAPTURE));
    wr_idx   = (state == ST_IDLE) ? 8'd0 : byte_cnt;
    cap_next = cap_q;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (byte_wr && (wr_idx == 8'(i))) begin
        cap_next[lp_W-1-i*8 -: 8] = mac_data_i;
      end
    end
  end

  eth_rx_frame_filter #(
    .FRAME_BYTES  (FRAME_BYTES),
    .ETHERTYPE    (ETHERTYPE),
    .IP_MATCH_EN  (IP_MATCH_EN),
    .IP_MATCH_OFS (IP_MATCH_OFS)
  ) u_filter (
    .frame   (cap_next),
    .hw_addr (hw_addr_i),
    .ip_addr (ip_addr_i),
    .match   (frame_match)
  );

  assign proto_pkt_o = cap_q;

  // Frame state machine: capture, skip trailing bytes, hold for the consumer,
  // and keep the accept/drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the capture register drives proto_pkt_o, which must read zero
      // out of reset, so it is reset like any other state despite its width.
      state             <= ST_IDLE;
      byte_cnt          <= 8'd0;
      cap_q             <= '0;
      match_q           <= 1'b0;
      busy_drop         <= 1'b0;
      proto_pkt_valid_o <= 1'b0;
      rx_ok_cnt_o       <= 16'd0;
      rx_drop_cnt_o     <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values regardless of statement order.
      if (byte_wr) begin
        cap_q <= cap_next;
      end

      case (state)
        ST_IDLE: begin
          if (mac_valid_i) begin
            if (mac_last_i) begin
              rx_drop_cnt_o <= sat_inc16(rx_drop_cnt_o);
            end else begin
              byte_cnt <= 8'd1;
              state    <= ST_CAPTURE;
            end
          end
        end

        ST_CAPTURE: begin
          if (mac_valid_i) begin
            if (byte_cnt == lp_LAST_IDX) begin
              if (!mac_last_i) begin
                match_q <= frame_match;
                state   <= ST_SKIP;
              end else if (frame_match && !mac_err_i) begin
                proto_pkt_valid_o <= 1'b1;
                busy_drop         <= 1'b0;
                rx_ok_cnt_o       <= sat_inc16(rx_ok_cnt_o);
                state             <= ST_HOLD;
              end else begin
                rx_drop_cnt_o <= sat_inc16(rx_drop_cnt_o);
                state         <= ST_IDLE;
              end
            end else if (mac_last_i) begin
              rx_drop_cnt_o <= sat_inc16(rx_drop_cnt_o);
              state         <= ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end

        ST_SKIP: begin
          if (mac_valid_i && mac_last_i) begin
            if (match_q && !mac_err_i) begin
              proto_pkt_valid_o <= 1'b1;
              busy_drop         <= 1'b0;
              rx_ok_cnt_o       <= sat_inc16(rx_ok_cnt_o);
              state             <= ST_HOLD;
            end else begin
              rx_drop_cnt_o <= sat_inc16(rx_drop_cnt_o);
              state         <= ST_IDLE;
            end
          end
        end

        ST_HOLD: begin
          // busy_drop marks a frame that began during the hold and has not
          // yet ended; its tail must be skipped once the consumer acks.
          if (proto_pkt_ack_i) begin
            proto_pkt_valid_o <= 1'b0;
            busy_drop         <= 1'b0;
            if (mac_valid_i ? !mac_last_i : busy_drop) begin
              match_q <= 1'b0;
              state   <= ST_SKIP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (mac_valid_i) begin
            busy_drop <= !mac_last_i;
          end
          if (mac_valid_i && mac_last_i) begin
            rx_drop_cnt_o <= sat_inc16(rx_drop_cnt_o);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_proto_receiver.sv
// Self-checking bench for eth_proto_receiver. A frame-level reference model
// decides each frame's fate from the acceptance rules (long enough, header
// fields match, no error, no byte consumed while a frame is held) and
// tracks the expected handshake and counters cycle by cycle.
module tb_eth_proto_receiver;
  import eth_proto_pkg::*;

  localparam int          FB = 42;
  localparam int          W  = FB * 8;
  localparam logic [47:0] HW = 48'h02_11_22_33_44_55;
  localparam logic [31:0] IP = 32'hC0A8_0164;

  localparam int K_GOOD_BC  = 0;
  localparam int K_GOOD_UC  = 1;
  localparam int K_BAD_TYPE = 2;
  localparam int K_BAD_TPA  = 3;
  localparam int K_BAD_MAC  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [47:0]   hw_addr_i;
  logic [31:0]   ip_addr_i;
  logic [7:0]    mac_data_i;
  logic          mac_valid_i;
  logic          mac_last_i;
  logic          mac_err_i;
  logic [W-1:0]  proto_pkt_o;
  logic          proto_pkt_valid_o;
  logic          proto_pkt_ack_i;
  logic [15:0]   rx_ok_cnt_o;
  logic [15:0]   rx_drop_cnt_o;

  always #5 clk = ~clk;

  eth_proto_receiver #(
    .FRAME_BYTES  (FB),
    .ETHERTYPE    (16'h0806),
    .IP_MATCH_EN  (1'b1),
    .IP_MATCH_OFS (38)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .hw_addr_i         (hw_addr_i),
    .ip_addr_i         (ip_addr_i),
    .mac_data_i        (mac_data_i),
    .mac_valid_i       (mac_valid_i),
    .mac_last_i        (mac_last_i),
    .mac_err_i         (mac_err_i),
    .proto_pkt_o       (proto_pkt_o),
    .proto_pkt_valid_o (proto_pkt_valid_o),
    .proto_pkt_ack_i   (proto_pkt_ack_i),
    .rx_ok_cnt_o       (rx_ok_cnt_o),
    .rx_drop_cnt_o     (rx_drop_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  bit           m_hold;
  bit           m_in_frame;
  bit           m_doomed;
  int           m_len;
  logic [7:0]   m_bytes [FB];
  logic [W-1:0] m_pkt;
  logic [15:0]  m_ok;
  logic [15:0]  m_drop;

  int         ack_pct;
  int         gap_pct;
  logic [7:0] fr[$];

  function automatic bit model_match();
    logic [47:0] dst;
    logic [15:0] et;
    logic [31:0] tpa;
    dst = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3], m_bytes[4], m_bytes[5]};
    et  = {m_bytes[12], m_bytes[13]};
    tpa = {m_bytes[38], m_bytes[39], m_bytes[40], m_bytes[41]};
    return ((dst == HW) || (dst == 48'hFFFF_FFFF_FFFF)) && (et == 16'h0806) && (tpa == IP);
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_hold     = 1'b0;
    m_in_frame = 1'b0;
    m_doomed   = 1'b0;
    m_len      = 0;
    m_pkt      = '0;
    m_ok       = 16'd0;
    m_drop     = 16'd0;
  endtask

  task automatic check_outputs();
    check("valid", W'(proto_pkt_valid_o), W'(m_hold));
    check("ok_cnt", W'(rx_ok_cnt_o), W'(m_ok));
    check("drop_cnt", W'(rx_drop_cnt_o), W'(m_drop));
    if (m_hold) check("pkt", proto_pkt_o, m_pkt);
  endtask

  // One clock: check the state left by the previous edge, then drive inputs
  // for the next edge and advance the model to match it.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit e, input bit a);
    bit accept;
    @(negedge clk);
    check_outputs();
    mac_valid_i     = v;
    mac_data_i      = d;
    mac_last_i      = l;
    mac_err_i       = e;
    proto_pkt_ack_i = a;
    accept = 1'b0;
    if (v) begin
      if (!m_in_frame) begin
        m_in_frame = 1'b1;
        m_len      = 0;
        m_doomed   = 1'b0;
      end
      if (m_hold) m_doomed = 1'b1;
      if (m_len < FB) m_bytes[m_len] = d;
      m_len++;
      if (l) begin
        m_in_frame = 1'b0;
        if (!m_doomed && (m_len >= FB) && model_match() && !e) begin
          accept = 1'b1;
          m_ok   = sat(m_ok);
        end else begin
          m_drop = sat(m_drop);
        end
      end
    end
    if (m_hold && a) m_hold = 1'b0;
    if (accept) begin
      m_hold = 1'b1;
      m_pkt  = '0;
      for (int i = 0; i < FB; i++) m_pkt = (m_pkt << 8) | W'(m_bytes[i]);
    end
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), a);
    end
  endtask

  // Streams fr; ack_at >= 0 acks only at that byte index, otherwise ack is random.
  task automatic send_frame(input bit err, input int ack_at);
    bit a;
    bit l;
    for (int i = 0; i < fr.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        idle(1, (ack_at < 0) && ($urandom_range(0, 99) < ack_pct));
      end
      a = (ack_at >= 0) ? (i == ack_at) : ($urandom_range(0, 99) < ack_pct);
      l = (i == fr.size() - 1);
      step(1'b1, fr[i], l, l ? err : 1'($urandom), a);
    end
  endtask

  task automatic make_frame(input int kind, input int len);
    logic [47:0] dst;
    logic [15:0] et;
    logic [31:0] tpa;
    logic [7:0]  b;
    logic [63:0] arp_fix;
    dst     = (kind == K_GOOD_BC) ? 48'hFFFF_FFFF_FFFF : HW;
    et      = 16'h0806;
    tpa     = IP;
    arp_fix = 64'h0001_0800_0604_0001;
    if (kind == K_BAD_TYPE) et = 16'h0800;
    if (kind == K_BAD_TPA)  tpa = IP ^ (32'd1 << $urandom_range(0, 31));
    if (kind == K_BAD_MAC)  dst = HW ^ (48'd1 << $urandom_range(0, 47));
    fr.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (i < 6)                  b = 8'(dst >> (8 * (5 - i)));
      else if (i == 12)           b = et[15:8];
      else if (i == 13)           b = et[7:0];
      else if (i >= 14 && i < 22) b = 8'(arp_fix >> (8 * (21 - i)));
      else if (i >= 38 && i < 42) b = 8'(tpa >> (8 * (41 - i)));
      fr.push_back(b);
    end
  endtask

  function automatic logic [W-1:0] pack_fr();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < FB; i++) p = (p << 8) | W'(fr[i]);
    return p;
  endfunction

  initial begin
    logic [W-1:0] exp_pkt;
    int kind;
    int len;

    rst             = 1'b1;
    hw_addr_i       = HW;
    ip_addr_i       = IP;
    mac_data_i      = 8'd0;
    mac_valid_i     = 1'b0;
    mac_last_i      = 1'b0;
    mac_err_i       = 1'b0;
    proto_pkt_ack_i = 1'b0;
    ack_pct         = 0;
    gap_pct         = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_pkt", proto_pkt_o, '0);
    check("rst_valid", W'(proto_pkt_valid_o), '0);
    check("rst_ok", W'(rx_ok_cnt_o), '0);
    check("rst_drop", W'(rx_drop_cnt_o), '0);
    check("rst_state", W'(dut.state), W'(ST_IDLE));
    rst = 1'b0;

    // Broadcast ARP request, 60 bytes + FCS, held unacked for 100 cycles.
    make_frame(K_GOOD_BC, 64);
    exp_pkt = pack_fr();
    send_frame(1'b0, -1);
    idle(1, 1'b0);
    check("first_valid", W'(proto_pkt_valid_o), W'(1'b1));
    check("first_pkt", proto_pkt_o, exp_pkt);
    check("first_ok", W'(rx_ok_cnt_o), W'(16'd1));
    idle(100, 1'b0);
    check("held_pkt", proto_pkt_o, exp_pkt);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("valid_after_ack", W'(proto_pkt_valid_o), '0);
    idle(5, 1'b1);

    // EtherType miss, target-IP miss, then an errored good frame.
    make_frame(K_BAD_TYPE, 64); send_frame(1'b0, -1);
    make_frame(K_BAD_TPA, 64);  send_frame(1'b0, -1);
    make_frame(K_GOOD_BC, 64);  send_frame(1'b1, -1);
    idle(2, 1'b0);
    check("filter_drops", W'(rx_drop_cnt_o), W'(16'd3));

    // Runts: 30 bytes, 1 byte, then 41 bytes; a 42-byte frame is complete.
    make_frame(K_GOOD_UC, 30); send_frame(1'b0, -1);
    make_frame(K_GOOD_UC, 1);  send_frame(1'b0, -1);
    idle(2, 1'b0);
    check("runt_drops", W'(rx_drop_cnt_o), W'(16'd5));
    check("runt_state", W'(dut.state), W'(ST_IDLE));
    make_frame(K_GOOD_UC, 41); send_frame(1'b0, -1);
    make_frame(K_GOOD_UC, 42); send_frame(1'b0, -1);
    idle(2, 1'b0);
    check("exact_len_ok", W'(rx_ok_cnt_o), W'(16'd2));
    idle(1, 1'b1);

    // Held frame; a second frame streams in and is acked mid-way, third accepted.
    make_frame(K_GOOD_UC, 64); exp_pkt = pack_fr(); send_frame(1'b0, -1);
    make_frame(K_GOOD_BC, 64); send_frame(1'b0, 30);
    idle(2, 1'b0);
    check("busy_drop", W'(rx_drop_cnt_o), W'(16'd7));
    make_frame(K_GOOD_BC, 50); send_frame(1'b0, -1);
    idle(1, 1'b0);
    check("third_ok", W'(rx_ok_cnt_o), W'(16'd4));
    // Frame whose first byte lands on the ack cycle is dropped; the next is not.
    make_frame(K_GOOD_BC, 48); send_frame(1'b0, 0);
    make_frame(K_GOOD_UC, 48); send_frame(1'b0, -1);
    idle(1, 1'b0);
    check("ack_cycle_ok", W'(rx_ok_cnt_o), W'(16'd5));
    check("ack_cycle_drop", W'(rx_drop_cnt_o), W'(16'd8));
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Reset after byte 20 of a capture; the tail counts as one dropped frame.
    make_frame(K_GOOD_BC, 64);
    for (int i = 0; i < 20; i++) step(1'b1, fr[i], 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    mac_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_pkt", proto_pkt_o, '0);
    check("mid_rst_ok", W'(rx_ok_cnt_o), '0);
    check("mid_rst_drop", W'(rx_drop_cnt_o), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    fr = fr[20:$];
    send_frame(1'b0, -1);
    make_frame(K_GOOD_UC, 64); send_frame(1'b0, -1);
    idle(1, 1'b0);
    check("post_rst_drop", W'(rx_drop_cnt_o), W'(16'd1));
    check("post_rst_ok", W'(rx_ok_cnt_o), W'(16'd1));
    idle(1, 1'b1);

    // Randomized mix of frame kinds, lengths, gaps and ack behaviour.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      len  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 41) : $urandom_range(42, 80);
      case ($urandom_range(0, 2))
        0:       ack_pct = 0;
        1:       ack_pct = 20;
        default: ack_pct = 100;
      endcase
      gap_pct = $urandom_range(0, 30);
      make_frame(kind, len);
      send_frame($urandom_range(0, 7) == 0, -1);
      idle($urandom_range(0, 3), $urandom_range(0, 99) < ack_pct);
    end

    idle(1, 1'b1);
    idle(3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
